// File: rtl/alu_cmd_ctrl_if.sv
// Command, ALU-side and response signals of the ALU command controller.
// The controller sits on the slave modport; the requester/ALU side uses master.
interface alu_cmd_ctrl_if #(
    parameter int WIDTHA   = 16,
    parameter int WIDTHART = 32
);
    logic                cmd_valid;
    logic                cmd_ready;
    logic [3:0]          cmd_fun;
    logic [WIDTHA-1:0]   cmd_a;
    logic [WIDTHA-1:0]   cmd_b;

    logic [WIDTHA-1:0]   alu_a;
    logic [WIDTHA-1:0]   alu_b;
    logic [3:0]          alu_fun;

    logic [WIDTHART-1:0] arith_out;
    logic                carry_out;
    logic                arith_flag;
    logic [WIDTHA-1:0]   logic_out;
    logic                logic_flag;
    logic [WIDTHA-1:0]   cmp_out;
    logic                cmp_flag;
    logic [WIDTHA-1:0]   shift_out;
    logic                shift_flag;

    logic                rsp_valid;
    logic                rsp_ready;
    logic [WIDTHART-1:0] rsp_data;
    logic                rsp_carry;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
        output arith_out, carry_out, arith_flag, logic_out, logic_flag,
        output cmp_out, cmp_flag, shift_out, shift_flag,
        input  cmd_ready, alu_a, alu_b, alu_fun,
        input  rsp_valid, rsp_data, rsp_carry, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_fun, cmd_a, cmd_b, rsp_ready,
        input  arith_out, carry_out, arith_flag, logic_out, logic_flag,
        input  cmp_out, cmp_flag, shift_out, shift_flag,
        output cmd_ready, alu_a, alu_b, alu_fun,
        output rsp_valid, rsp_data, rsp_carry, rsp_err
    );
endinterface

// File: rtl/alu_cmd_ctrl.sv
// Sequences one ALU command at a time: latch operands, wait for the class flag, return a response.
// Optional SAMPLE timeout enabled by defining ALU_CMD_CTRL_TIMEOUT_EN.
module alu_cmd_ctrl #(
    parameter int WIDTHA   = 16,
    parameter int WIDTHART = 32,
    parameter int TIMEOUT  = 15
) (
    input  logic         CLK,
    input  logic         RST,
    alu_cmd_ctrl_if.slave bus,
    output logic [1:0]   fsm_state
);
    // Both channels transfer on a rising edge where valid and ready are both 1;
    // a producer holds valid and its payload stable until that edge.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        SAMPLE = 2'd2,
        RESP   = 2'd3
    } state_t;

    state_t              state;
    logic                exp_flag;
    logic [WIDTHART-1:0] exp_data;
    logic                exp_carry;

    assign fsm_state = state;

    // Only the class selected by the latched function may complete the op.
    always_comb begin
        exp_flag  = 1'b0;
        exp_data  = '0;
        exp_carry = 1'b0;
        case (bus.alu_fun[3:2])
            2'b00: begin
                exp_flag  = bus.arith_flag;
                exp_data  = bus.arith_out;
                exp_carry = bus.carry_out;
            end
            2'b01: begin
                exp_flag = bus.logic_flag;
                exp_data = WIDTHART'(bus.logic_out);
            end
            2'b10: begin
                exp_flag = bus.cmp_flag;
                exp_data = WIDTHART'(bus.cmp_out);
            end
            default: begin
                exp_flag = bus.shift_flag;
                exp_data = WIDTHART'(bus.shift_out);
            end
        endcase
    end

`ifdef ALU_CMD_CTRL_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT + 1);
    logic [CNT_W-1:0] tmo_cnt;
    logic [CNT_W-1:0] tmo_nxt;
    logic             err;

    assign tmo_nxt     = tmo_cnt + 1'b1;
    assign bus.rsp_err = err;
`else
    assign bus.rsp_err = 1'b0;
`endif

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state         <= IDLE;
            bus.cmd_ready <= 1'b1;
            bus.alu_a     <= '0;
            bus.alu_b     <= '0;
            bus.alu_fun   <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_data  <= '0;
            bus.rsp_carry <= 1'b0;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
            tmo_cnt       <= '0;
            err           <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (bus.cmd_valid && bus.cmd_ready) begin
                        bus.alu_a     <= bus.cmd_a;
                        bus.alu_b     <= bus.cmd_b;
                        bus.alu_fun   <= bus.cmd_fun;
                        bus.cmd_ready <= 1'b0;
                        state         <= WAIT;
                    end
                end
                // Flags seen here still belong to the previous operation.
                WAIT: begin
                    state <= SAMPLE;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                    tmo_cnt <= '0;
`endif
                end
                SAMPLE: begin
                    if (exp_flag) begin
                        bus.rsp_data  <= exp_data;
                        bus.rsp_carry <= exp_carry;
                        bus.rsp_valid <= 1'b1;
                        state         <= RESP;
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
                        err           <= 1'b0;
                    end else begin
                        tmo_cnt <= tmo_nxt;
                        if (tmo_nxt == CNT_W'(TIMEOUT)) begin
                            bus.rsp_data  <= '0;
                            bus.rsp_carry <= 1'b0;
                            bus.rsp_valid <= 1'b1;
                            err           <= 1'b1;
                            state         <= RESP;
                        end
`endif
                    end
                end
                default: begin
                    if (bus.rsp_ready) begin
                        bus.rsp_valid <= 1'b0;
                        bus.cmd_ready <= 1'b1;
                        state         <= IDLE;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// Directed bench for alu_cmd_ctrl with a registered behavioural ALU stub.
// Define ALU_CMD_CTRL_TIMEOUT_EN for both RTL and bench to cover the timeout build.
module tb_alu_cmd_ctrl;
    localparam int WA = 16;
    localparam int WR = 32;
    localparam int TO = 15;

    localparam logic [1:0] S_IDLE   = 2'd0;
    localparam logic [1:0] S_WAIT   = 2'd1;
    localparam logic [1:0] S_SAMPLE = 2'd2;
    localparam logic [1:0] S_RESP   = 2'd3;

    logic       CLK = 1'b0;
    logic       RST = 1'b1;
    logic [1:0] fsm_state;

    alu_cmd_ctrl_if #(.WIDTHA(WA), .WIDTHART(WR)) bus ();

    alu_cmd_ctrl #(.WIDTHA(WA), .WIDTHART(WR), .TIMEOUT(TO)) dut (
        .CLK       (CLK),
        .RST       (RST),
        .bus       (bus.slave),
        .fsm_state (fsm_state)
    );

    // ---------------- clock / reset ----------------
    always #5 CLK = ~CLK;

    // ---------------- ALU stub ----------------
    // flag_en bits: [0] arith, [1] logic, [2] cmp, [3] shift; flag_force raises a flag regardless of class.
    logic [3:0] flag_en;
    logic [3:0] flag_force;
    logic       stub_carry;

    always_ff @(posedge CLK) begin
        bus.arith_out  <= WR'(bus.alu_a) + WR'(bus.alu_b);
        bus.carry_out  <= stub_carry;
        bus.logic_out  <= bus.alu_a ^ bus.alu_b;
        bus.cmp_out    <= (bus.alu_a < bus.alu_b) ? 16'd1 : 16'd0;
        bus.shift_out  <= bus.alu_a << bus.alu_b[3:0];
        bus.arith_flag <= ((bus.alu_fun[3:2] == 2'b00) && flag_en[0]) || flag_force[0];
        bus.logic_flag <= ((bus.alu_fun[3:2] == 2'b01) && flag_en[1]) || flag_force[1];
        bus.cmp_flag   <= ((bus.alu_fun[3:2] == 2'b10) && flag_en[2]) || flag_force[2];
        bus.shift_flag <= ((bus.alu_fun[3:2] == 2'b11) && flag_en[3]) || flag_force[3];
    end

    // ---------------- scoreboard state ----------------
    int            n_vec = 0;
    int            n_err = 0;
    logic [WR-1:0] exp_q[$];
    logic [WR-1:0] exp_d;
    logic          rdy;
    int            lat;
    logic [WR-1:0] d;
    logic          c;
    logic          e;

    // ---------------- driver tasks ----------------
    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic send_cmd(input logic [3:0] fun, input logic [WA-1:0] a, input logic [WA-1:0] b,
                            output logic ready_seen);
        bus.cmd_valid = 1'b1;
        bus.cmd_fun   = fun;
        bus.cmd_a     = a;
        bus.cmd_b     = b;
        ready_seen    = bus.cmd_ready;
        @(posedge CLK);
        @(negedge CLK);
        bus.cmd_valid = 1'b0;
    endtask

    // Counts rising edges until rsp_valid is seen; lat = -1 if the budget expires.
    task automatic wait_rsp(input int limit, output int lat_o, output logic [WR-1:0] data_o,
                            output logic carry_o, output logic err_o);
        lat_o   = -1;
        data_o  = '0;
        carry_o = 1'b0;
        err_o   = 1'b0;
        for (int i = 1; i <= limit; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            if (bus.rsp_valid) begin
                lat_o   = i;
                data_o  = bus.rsp_data;
                carry_o = bus.rsp_carry;
                err_o   = bus.rsp_err;
                break;
            end
        end
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        bus.cmd_valid = 1'b0;
        bus.cmd_fun   = '0;
        bus.cmd_a     = '0;
        bus.cmd_b     = '0;
        bus.rsp_ready = 1'b1;
        flag_en       = 4'hF;
        flag_force    = 4'h0;
        stub_carry    = 1'b0;
        RST           = 1'b1;
        repeat (2) @(negedge CLK);
        n_vec++; if (bus.cmd_ready !== 1'b1) begin n_err++; $display("FAIL reset_cmd_ready: got %b want 1", bus.cmd_ready); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL reset_rsp_valid: got %b want 0", bus.rsp_valid); end
        n_vec++; if (bus.rsp_data !== 32'h0) begin n_err++; $display("FAIL reset_rsp_data: got %h want 0", bus.rsp_data); end
        n_vec++; if (bus.rsp_carry !== 1'b0) begin n_err++; $display("FAIL reset_rsp_carry: got %b want 0", bus.rsp_carry); end
        n_vec++; if (bus.rsp_err !== 1'b0) begin n_err++; $display("FAIL reset_rsp_err: got %b want 0", bus.rsp_err); end
        n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== 36'h0) begin n_err++; $display("FAIL reset_alu: got %h/%h/%h want 0", bus.alu_a, bus.alu_b, bus.alu_fun); end
        n_vec++; if (fsm_state !== S_IDLE) begin n_err++; $display("FAIL reset_state: got %0d want %0d", fsm_state, S_IDLE); end
    endtask

    // First command presented on the cycle reset drops.
    task automatic test_arith_first();
        RST = 1'b0;
        exp_q.push_back(32'h0000_0008);
        send_cmd(4'b0000, 16'd3, 16'd5, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL first_ready: got %b want 1", rdy); end
        n_vec++; if (fsm_state !== S_WAIT) begin n_err++; $display("FAIL first_accept_state: got %0d want %0d", fsm_state, S_WAIT); end
        n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== {16'd3, 16'd5, 4'b0000}) begin n_err++; $display("FAIL first_alu_regs: got %h/%h/%h want 3/5/0", bus.alu_a, bus.alu_b, bus.alu_fun); end
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL first_early_valid: got %b want 0", bus.rsp_valid); end
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL arith_latency: got %0d want 2", lat); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL arith_data: got %h want %h", d, exp_d); end
        n_vec++; if ({c, e} !== 2'b00) begin n_err++; $display("FAIL arith_carry_err: got %b%b want 00", c, e); end
        @(negedge CLK);
        n_vec++; if ({fsm_state, bus.cmd_ready} !== {S_IDLE, 1'b1}) begin n_err++; $display("FAIL arith_back_idle: got %0d/%b want 0/1", fsm_state, bus.cmd_ready); end
    endtask

    task automatic test_carry();
        stub_carry = 1'b1;
        exp_q.push_back(32'h0001_0000);
        send_cmd(4'b0011, 16'hFFFF, 16'h0001, rdy);
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL carry_latency: got %0d want 2", lat); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL carry_data: got %h want %h", d, exp_d); end
        n_vec++; if (c !== 1'b1) begin n_err++; $display("FAIL carry_flag: got %b want 1", c); end
        stub_carry = 1'b0;
        @(negedge CLK);
    endtask

    // Wrong-class flag (cmp) must not complete a logic op; carry is forced 0 for non-arith.
    task automatic test_logic_flag_select();
        flag_en    = 4'b1101;
        flag_force = 4'b0100;
        stub_carry = 1'b1;
        exp_q.push_back(32'h0000_00F0);
        send_cmd(4'b0100, 16'h00FF, 16'h000F, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL logic_ready: got %b want 1", rdy); end
        for (int i = 0; i < 4; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL logic_no_rsp cycle %0d: got %b want 0", i, bus.rsp_valid); end
        end
        n_vec++; if (fsm_state !== S_SAMPLE) begin n_err++; $display("FAIL logic_in_sample: got %0d want %0d", fsm_state, S_SAMPLE); end
        flag_en    = 4'hF;
        flag_force = 4'h0;
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL logic_flag_latency: got %0d want 2", lat); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL logic_data: got %h want %h", d, exp_d); end
        n_vec++; if ({c, e} !== 2'b00) begin n_err++; $display("FAIL logic_carry_err: got %b%b want 00", c, e); end
        stub_carry = 1'b0;
        @(negedge CLK);
    endtask

    // Response held under backpressure; cmd_valid outside IDLE and on the handshake cycle is ignored.
    task automatic test_backpressure();
        bus.rsp_ready = 1'b0;
        exp_q.push_back(32'h0000_0030);
        send_cmd(4'b0001, 16'h0010, 16'h0020, rdy);
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL bp_latency: got %0d want 2", lat); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL bp_data: got %h want %h", d, exp_d); end
        bus.cmd_valid = 1'b1;
        bus.cmd_fun   = 4'b0100;
        bus.cmd_a     = 16'hAAAA;
        bus.cmd_b     = 16'h5555;
        for (int i = 0; i < 3; i++) begin
            @(posedge CLK);
            @(negedge CLK);
            n_vec++; if ({bus.rsp_valid, bus.cmd_ready, fsm_state} !== {1'b1, 1'b0, S_RESP}) begin n_err++; $display("FAIL bp_hold cycle %0d: got v=%b r=%b s=%0d want 1/0/3", i, bus.rsp_valid, bus.cmd_ready, fsm_state); end
            n_vec++; if (bus.rsp_data !== exp_d) begin n_err++; $display("FAIL bp_data_stable cycle %0d: got %h want %h", i, bus.rsp_data, exp_d); end
            n_vec++; if (bus.alu_a !== 16'h0010) begin n_err++; $display("FAIL bp_alu_hold cycle %0d: got %h want 0010", i, bus.alu_a); end
        end
        bus.rsp_ready = 1'b1;
        @(posedge CLK);
        @(negedge CLK);
        n_vec++; if ({fsm_state, bus.rsp_valid, bus.cmd_ready} !== {S_IDLE, 1'b0, 1'b1}) begin n_err++; $display("FAIL bp_release: got s=%0d v=%b r=%b want 0/0/1", fsm_state, bus.rsp_valid, bus.cmd_ready); end
        bus.cmd_valid = 1'b0;
    endtask

    // Previous op was arith, so arith_flag is still 1 with the old result during WAIT.
    task automatic test_stale_flag();
        exp_q.push_back(32'h0000_1234);
        send_cmd(4'b0010, 16'h1000, 16'h0234, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL stale_ready: got %b want 1", rdy); end
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL stale_latency: got %0d want 2", lat); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL stale_data: got %h want %h", d, exp_d); end
        @(negedge CLK);
    endtask

    task automatic test_cmp_shift();
        logic [3:0]    funs [3];
        logic [WA-1:0] as   [3];
        logic [WA-1:0] bs   [3];
        logic [WR-1:0] exps [3];
        funs = '{4'b1000, 4'b1011, 4'b1100};
        as   = '{16'd2,   16'd9,   16'h0003};
        bs   = '{16'd7,   16'd7,   16'd4};
        exps = '{32'h1,   32'h0,   32'h30};
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back(exps[i]);
            send_cmd(funs[i], as[i], bs[i], rdy);
            wait_rsp(8, lat, d, c, e);
            exp_d = exp_q.pop_front();
            n_vec++; if (lat !== 2) begin n_err++; $display("FAIL cs%0d_latency: got %0d want 2", i, lat); end
            n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL cs%0d_data: got %h want %h", i, d, exp_d); end
            @(negedge CLK);
        end
    endtask

    task automatic test_timeout();
        flag_en = 4'b0111;
        send_cmd(4'b1100, 16'h0001, 16'h0002, rdy);
`ifdef ALU_CMD_CTRL_TIMEOUT_EN
        exp_q.push_back(32'h0);
        wait_rsp(40, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== TO + 1) begin n_err++; $display("FAIL tmo_latency: got %0d want %0d", lat, TO + 1); end
        n_vec++; if (d !== exp_d) begin n_err++; $display("FAIL tmo_data: got %h want %h", d, exp_d); end
        n_vec++; if ({c, e} !== 2'b01) begin n_err++; $display("FAIL tmo_carry_err: got %b%b want 01", c, e); end
        flag_en = 4'hF;
        @(negedge CLK);
`else
        wait_rsp(20, lat, d, c, e);
        n_vec++; if (lat !== -1) begin n_err++; $display("FAIL notmo_no_rsp: got latency %0d want none", lat); end
        n_vec++; if (fsm_state !== S_SAMPLE) begin n_err++; $display("FAIL notmo_state: got %0d want %0d", fsm_state, S_SAMPLE); end
        flag_en = 4'hF;
        exp_q.push_back(32'h4);
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL notmo_latency: got %0d want 2", lat); end
        n_vec++; if ({d, e} !== {exp_d, 1'b0}) begin n_err++; $display("FAIL notmo_data_err: got %h/%b want %h/0", d, e, exp_d); end
        @(negedge CLK);
`endif
    endtask

    task automatic test_reset_mid();
        flag_en = 4'b1101;
        send_cmd(4'b0100, 16'h00FF, 16'h0F0F, rdy);
        @(posedge CLK);
        @(negedge CLK);
        n_vec++; if (fsm_state !== S_SAMPLE) begin n_err++; $display("FAIL mid_pre_state: got %0d want %0d", fsm_state, S_SAMPLE); end
        #2 RST = 1'b1;
        #1;
        n_vec++; if ({fsm_state, bus.cmd_ready, bus.rsp_valid} !== {S_IDLE, 1'b1, 1'b0}) begin n_err++; $display("FAIL mid_rst_ctrl: got s=%0d r=%b v=%b want 0/1/0", fsm_state, bus.cmd_ready, bus.rsp_valid); end
        n_vec++; if ({bus.rsp_data, bus.rsp_carry, bus.rsp_err} !== 34'h0) begin n_err++; $display("FAIL mid_rst_rsp: got %h/%b/%b want 0", bus.rsp_data, bus.rsp_carry, bus.rsp_err); end
        n_vec++; if ({bus.alu_a, bus.alu_b, bus.alu_fun} !== 36'h0) begin n_err++; $display("FAIL mid_rst_alu: got %h/%h/%h want 0", bus.alu_a, bus.alu_b, bus.alu_fun); end
        flag_en = 4'hF;
        @(negedge CLK);
        n_vec++; if (bus.rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_hold_valid: got %b want 0", bus.rsp_valid); end
        RST = 1'b0;
        exp_q.push_back(32'h0000_0010);
        send_cmd(4'b0000, 16'd7, 16'd9, rdy);
        n_vec++; if (rdy !== 1'b1) begin n_err++; $display("FAIL mid_next_ready: got %b want 1", rdy); end
        wait_rsp(8, lat, d, c, e);
        exp_d = exp_q.pop_front();
        n_vec++; if (lat !== 2) begin n_err++; $display("FAIL mid_next_latency: got %0d want 2", lat); end
        n_vec++; if ({d, c, e} !== {exp_d, 2'b00}) begin n_err++; $display("FAIL mid_next_rsp: got %h/%b/%b want %h/0/0", d, c, e, exp_d); end
        @(negedge CLK);
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_arith_first();
        test_carry();
        test_logic_flag_select();
        test_backpressure();
        test_stale_flag();
        test_cmp_shift();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #100000;
        n_err++;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/alu_cmd_ctrl.md
ALU_CMD_CTRL -- requirements
Module: alu_cmd_ctrl

Interface
REQ-001 The block SHALL have parameter WIDTHA, default 16, meaning the operand and logic/cmp/shift result width.
REQ-002 The block SHALL have parameter WIDTHART, default 32, meaning the arithmetic result and response data width.
REQ-003 The block SHALL have parameter TIMEOUT, default 15, meaning the maximum SAMPLE cycles spent waiting for the expected flag.
REQ-004 Port CLK, input, 1, is the single clock; all state changes SHALL occur on its rising edge.
REQ-005 Port RST, input, 1, is the reset; it SHALL be asynchronous and active-high.
REQ-006 Ports cmd_valid input 1, cmd_ready output 1, cmd_fun input 4, cmd_a input WIDTHA, cmd_b input WIDTHA SHALL form the command channel.
REQ-007 Ports alu_a output WIDTHA, alu_b output WIDTHA, alu_fun output 4 SHALL drive the ALU operand and function inputs.
REQ-008 Ports arith_out input WIDTHART, carry_out input 1, arith_flag input 1, logic_out input WIDTHA, logic_flag input 1, cmp_out input WIDTHA, cmp_flag input 1, shift_out input WIDTHA, shift_flag input 1 SHALL receive the registered ALU results.
REQ-009 Ports rsp_valid output 1, rsp_ready input 1, rsp_data output WIDTHART, rsp_carry output 1, rsp_err output 1 SHALL form the response channel.

Function
REQ-010 The FSM SHALL have the states IDLE, WAIT, SAMPLE and RESP.
REQ-011 cmd_ready SHALL be 1 only in IDLE, and a command SHALL be accepted on an edge where cmd_valid=1 and cmd_ready=1.
REQ-012 On acceptance, alu_a/alu_b/alu_fun SHALL register cmd_a/cmd_b/cmd_fun, the state SHALL go to WAIT, and the ALU outputs SHALL hold these values until the next acceptance.
REQ-013 The expected class SHALL decode as cmd_fun[3:2]: 00 selects arith, 01 logic, 10 cmp, 11 shift.
REQ-014 WAIT SHALL last exactly one cycle and SHALL ignore all flags, so stale flags from the previous operation are discarded; the state then goes to SAMPLE.
REQ-015 In SAMPLE, when the flag of the expected class is 1, the block SHALL capture the result, set rsp_err=0, and go to RESP; flags of other classes SHALL be ignored.
REQ-016 Captured data SHALL be arith_out with rsp_carry=carry_out for the arith class; for the other classes it SHALL be the class output zero-extended to WIDTHART with rsp_carry=0.
REQ-017 Minimum latency SHALL be rsp_valid=1 two cycles after the acceptance edge.
REQ-018 rsp_valid SHALL be 1 only in RESP, and rsp_data/rsp_carry/rsp_err SHALL stay stable while rsp_valid=1 and rsp_ready=0.
REQ-019 On rsp_valid=1 and rsp_ready=1 the state SHALL go to IDLE; a new command SHALL NOT be accepted in that same cycle.
REQ-020 cmd_valid SHALL be ignored outside IDLE.

Reset
REQ-021 While RST=1 the state SHALL be IDLE and cmd_ready SHALL be 1.
REQ-022 While RST=1, rsp_valid, rsp_data, rsp_carry, rsp_err, alu_a, alu_b, alu_fun and the timeout counter SHALL all be 0.
REQ-023 A reset asserted mid-operation (WAIT, SAMPLE or RESP) SHALL abort it immediately with no response issued.
REQ-024 The first command after RST deasserts SHALL be acceptable on the first rising edge.

Configuration
REQ-025 Macro ALU_CMD_CTRL_TIMEOUT_EN, when defined, SHALL enable a counter that clears on entry to SAMPLE and increments each SAMPLE cycle without the expected flag.
REQ-026 With ALU_CMD_CTRL_TIMEOUT_EN defined, when the counter reaches TIMEOUT the block SHALL go to RESP with rsp_err=1, rsp_data=0 and rsp_carry=0.
REQ-027 Without ALU_CMD_CTRL_TIMEOUT_EN, the block SHALL remain in SAMPLE indefinitely until the expected flag, SHALL tie rsp_err to 0, and SHALL implement no counter logic.

Verification
REQ-028 The bench SHALL drive ALU-side inputs from a behavioural stub that registers flags and results one cycle after alu_* change.
REQ-029 Scenario: cmd_fun=0000, A=3, B=5, stub arith_out=0x00000008, carry_out=0 -> rsp_valid 2 cycles after acceptance, rsp_data=0x00000008, rsp_carry=0, rsp_err=0.
REQ-030 Scenario: cmd_fun=0100, stub logic_out=0x00F0 -> rsp_data=0x000000F0; logic_flag=0 with cmp_flag=1 in the first SAMPLE cycle -> no response until logic_flag=1.
REQ-031 Scenario: rsp_ready held 0 for 3 cycles -> rsp_valid=1 with rsp_data stable, cmd_ready=0; rsp_ready=1 -> IDLE next cycle.
REQ-032 Scenario: arith_flag held 1 from a prior arith op, new arith op issued -> WAIT ignores the stale flag and the response carries the new arith_out.
REQ-033 Scenario, ALU_CMD_CTRL_TIMEOUT_EN defined: shift op, shift_flag never asserted -> rsp_valid after 15 SAMPLE cycles with rsp_err=1, rsp_data=0.
REQ-034 Scenario: RST pulsed while in SAMPLE -> all outputs 0, cmd_ready=1, no rsp_valid; the next command completes normally.
